// File: rtl/io_loopback_tester.sv
// N-channel IO loopback tester: one shared pattern generator, and per channel an RX synchroniser,
// a self-synchronising pattern checker, lock/error tracking and a gated rising-edge counter.
module io_loopback_tester #(
    parameter int N_CH        = 5,
    parameter int CNT_W       = 32,
    parameter int GATE_CYCLES = 50000000,
    parameter int SYNC_STAGES = 2,
    parameter int LOCK_THRESH = 16
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic                                       en,
    input  logic [1:0]                                 mode,
    input  logic                                       clr,
    output logic [N_CH-1:0]                            tx_o,
    input  logic [N_CH-1:0]                            rx_i,
    output logic [N_CH-1:0]                            lock,
    output logic                                       gate_tick,
    input  logic [((N_CH > 1) ? $clog2(N_CH) : 1)-1:0] rd_sel,
    output logic [CNT_W-1:0]                           rd_err_cnt,
    output logic [CNT_W-1:0]                           rd_edge_cnt
);

    localparam int              SEL_W   = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int              GATE_W  = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
    localparam int              RUN_W   = $clog2(LOCK_THRESH + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [14:0]     SEED    = '1;

    genvar gi;

    // ------------------------------------------------------------------
    // Shared generator
    // ------------------------------------------------------------------
    logic                   en_reg;
    logic [1:0]             mode_reg;
    logic [14:0]            lfsr_reg, lfsr_next, gen_src;
    logic                   tog_reg, tog_next, tog_src;
    logic                   tx_reg, tx_next;
    logic [SYNC_STAGES-1:0] restart_pipe_reg;
    logic                   restart, fill_clear, chk_clear;

    assign restart    = en & (~en_reg | (mode != mode_reg));
    // The history is refilled when the first post-restart bit reaches the end of the synchroniser,
    // so stale pre-restart bits never take part in a check.
    assign fill_clear = ~en | restart | restart_pipe_reg[SYNC_STAGES-1];
    assign chk_clear  = fill_clear | clr;

    always_comb begin
        gen_src   = restart ? SEED : lfsr_reg;
        tog_src   = restart ? 1'b0 : tog_reg;
        lfsr_next = SEED;
        tog_next  = 1'b0;
        tx_next   = 1'b0;
        if (en) begin
            case (mode)
                2'd0: begin
                    tx_next  = tog_src;
                    tog_next = ~tog_src;
                end
                2'd1: begin
                    tx_next   = gen_src[6];
                    lfsr_next = {gen_src[14:7], gen_src[5:0], gen_src[6] ^ gen_src[5]};
                end
                2'd2: begin
                    tx_next   = gen_src[14];
                    lfsr_next = {gen_src[13:0], gen_src[14] ^ gen_src[13]};
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            en_reg           <= 1'b0;
            mode_reg         <= 2'd0;
            lfsr_reg         <= SEED;
            tog_reg          <= 1'b0;
            tx_reg           <= 1'b0;
            restart_pipe_reg <= '0;
        end else begin
            en_reg           <= en;
            mode_reg         <= mode;
            lfsr_reg         <= lfsr_next;
            tog_reg          <= tog_next;
            tx_reg           <= tx_next;
            restart_pipe_reg <= {restart_pipe_reg[SYNC_STAGES-2:0], restart};
        end
    end

    assign tx_o = {N_CH{tx_reg}};

    // ------------------------------------------------------------------
    // Gate timer
    // ------------------------------------------------------------------
    logic [GATE_W-1:0] gate_reg, gate_next;

    assign gate_tick = (gate_reg == GATE_W'(GATE_CYCLES - 1));
    assign gate_next = (clr | gate_tick) ? '0 : gate_reg + GATE_W'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) gate_reg <= '0;
        else     gate_reg <= gate_next;
    end

    // ------------------------------------------------------------------
    // Per-channel receive, check and count
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] err_cnt  [N_CH];
    logic [CNT_W-1:0] edge_lat [N_CH];

    generate
        for (gi = 0; gi < N_CH; gi++) begin : g_ch
            logic [SYNC_STAGES-1:0] sync_reg;
            logic [14:0]            hist_reg;
            logic [3:0]             fill_reg, fill_next;
            logic [RUN_W-1:0]       run_reg, run_next;
            logic                   lock_reg, lock_next;
            logic                   armed_reg, armed_next;
            logic [CNT_W-1:0]       err_reg, err_next;
            logic [CNT_W-1:0]       edge_run_reg, edge_run_next;
            logic [CNT_W-1:0]       edge_lat_reg, edge_lat_next;
            logic [CNT_W-1:0]       edge_sum;
            logic                   bit_in, rise, expected, filled, check_en;

            assign bit_in   = sync_reg[SYNC_STAGES-1];
            assign rise     = bit_in & ~hist_reg[0];
            assign check_en = en & filled & ~fill_clear;

            // Idle mode leaves filled low, which disables the checker.
            always_comb begin
                expected = 1'b0;
                filled   = 1'b0;
                case (mode_reg)
                    2'd0: begin
                        expected = ~hist_reg[0];
                        filled   = (fill_reg >= 4'd1);
                    end
                    2'd1: begin
                        expected = hist_reg[6] ^ hist_reg[5];
                        filled   = (fill_reg >= 4'd7);
                    end
                    2'd2: begin
                        expected = hist_reg[14] ^ hist_reg[13];
                        filled   = (fill_reg >= 4'd15);
                    end
                    default: ;
                endcase
            end

            always_comb begin
                fill_next     = fill_reg;
                run_next      = run_reg;
                lock_next     = lock_reg;
                armed_next    = armed_reg;
                err_next      = err_reg;
                edge_run_next = edge_run_reg;
                edge_lat_next = edge_lat_reg;
                edge_sum      = edge_run_reg;

                if (fill_clear)              fill_next = 4'd0;
                else if (fill_reg != 4'd15)  fill_next = fill_reg + 4'd1;

                if (check_en) begin
                    if (bit_in == expected) begin
                        if (run_reg != RUN_W'(LOCK_THRESH)) run_next = run_reg + RUN_W'(1);
                        if (run_next == RUN_W'(LOCK_THRESH)) begin
                            lock_next  = 1'b1;
                            armed_next = 1'b1;
                        end
                    end else begin
                        run_next  = '0;
                        lock_next = 1'b0;
                        if (armed_reg && err_reg != CNT_MAX) err_next = err_reg + CNT_W'(1);
                    end
                end
                if (chk_clear) begin
                    run_next   = '0;
                    lock_next  = 1'b0;
                    armed_next = 1'b0;
                end

                if (rise && edge_run_reg != CNT_MAX) edge_sum = edge_run_reg + CNT_W'(1);
                if (gate_tick) begin
                    edge_lat_next = edge_sum;
                    edge_run_next = '0;
                end else begin
                    edge_run_next = edge_sum;
                end

                if (clr) begin
                    err_next      = '0;
                    edge_run_next = '0;
                    edge_lat_next = '0;
                end
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    sync_reg     <= '0;
                    hist_reg     <= '0;
                    fill_reg     <= 4'd0;
                    run_reg      <= '0;
                    lock_reg     <= 1'b0;
                    armed_reg    <= 1'b0;
                    err_reg      <= '0;
                    edge_run_reg <= '0;
                    edge_lat_reg <= '0;
                end else begin
                    sync_reg     <= {sync_reg[SYNC_STAGES-2:0], rx_i[gi]};
                    hist_reg     <= {hist_reg[13:0], bit_in};
                    fill_reg     <= fill_next;
                    run_reg      <= run_next;
                    lock_reg     <= lock_next;
                    armed_reg    <= armed_next;
                    err_reg      <= err_next;
                    edge_run_reg <= edge_run_next;
                    edge_lat_reg <= edge_lat_next;
                end
            end

            assign lock[gi]     = lock_reg;
            assign err_cnt[gi]  = err_reg;
            assign edge_lat[gi] = edge_lat_reg;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Readback: unused select codes read as zero
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] err_pad  [2**SEL_W];
    logic [CNT_W-1:0] edge_pad [2**SEL_W];

    generate
        for (gi = 0; gi < 2**SEL_W; gi++) begin : g_pad
            if (gi < N_CH) begin : g_used
                assign err_pad[gi]  = err_cnt[gi];
                assign edge_pad[gi] = edge_lat[gi];
            end else begin : g_unused
                assign err_pad[gi]  = '0;
                assign edge_pad[gi] = '0;
            end
        end
    endgenerate

    logic [CNT_W-1:0] rd_err_reg, rd_edge_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_err_reg  <= '0;
            rd_edge_reg <= '0;
        end else begin
            rd_err_reg  <= err_pad[rd_sel];
            rd_edge_reg <= edge_pad[rd_sel];
        end
    end

    assign rd_err_cnt  = rd_err_reg;
    assign rd_edge_cnt = rd_edge_reg;

endmodule

// File: tb/tb_io_loopback_tester.sv
// Directed bench for io_loopback_tester: loopback lock, fault injection, gated edge counts,
// idle mode, error saturation with clear, and asynchronous reset.
module tb_io_loopback_tester;

    localparam int N_CH = 5;
    localparam int CNT_W = 32;
    localparam int GATE = 1000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // Main instance
    logic              en, clr, gate_tick, hold0;
    logic [1:0]        mode;
    logic [2:0]        rd_sel;
    logic [N_CH-1:0]   tx_o, rx_i, lock, mask;
    logic [CNT_W-1:0]  rd_err_cnt, rd_edge_cnt;

    assign rx_i = hold0 ? '0 : (tx_o ^ mask);

    io_loopback_tester #(
        .N_CH(N_CH), .CNT_W(CNT_W), .GATE_CYCLES(GATE), .SYNC_STAGES(2), .LOCK_THRESH(16)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .clr(clr),
        .tx_o(tx_o), .rx_i(rx_i), .lock(lock), .gate_tick(gate_tick),
        .rd_sel(rd_sel), .rd_err_cnt(rd_err_cnt), .rd_edge_cnt(rd_edge_cnt)
    );

    // Narrow-counter instance for saturation
    logic        en_s, clr_s, tick_s, rd_sel_s;
    logic [1:0]  mode_s, tx_s, rx_s, lock_s, mask_s;
    logic [3:0]  err_s, edge_s;

    assign rx_s = tx_s ^ mask_s;

    io_loopback_tester #(
        .N_CH(2), .CNT_W(4), .GATE_CYCLES(GATE), .SYNC_STAGES(2), .LOCK_THRESH(16)
    ) dut_s (
        .clk(clk), .rst(rst), .en(en_s), .mode(mode_s), .clr(clr_s),
        .tx_o(tx_s), .rx_i(rx_s), .lock(lock_s), .gate_tick(tick_s),
        .rd_sel(rd_sel_s), .rd_err_cnt(err_s), .rd_edge_cnt(edge_s)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end else begin
            $display("ok   %s: %0d", tag, got);
        end
    endtask

    task automatic wait_lock(input logic [N_CH-1:0] want, input int max_cyc, output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (lock !== want && cyc <= max_cyc);
    endtask

    task automatic wait_tick(input int max_cyc, output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (gate_tick !== 1'b1 && cyc <= max_cyc);
    endtask

    task automatic read_ch(input int c, output logic [CNT_W-1:0] e, output logic [CNT_W-1:0] g);
        rd_sel = 3'(c);
        @(negedge clk);
        e = rd_err_cnt;
        g = rd_edge_cnt;
    endtask

    initial begin
        int cyc, relock;
        logic dropped;
        logic [CNT_W-1:0] e, g;

        en = 0; mode = 2'd1; clr = 0; rd_sel = 0; mask = '0; hold0 = 0;
        en_s = 0; mode_s = 2'd2; clr_s = 0; rd_sel_s = 0; mask_s = '0;

        repeat (3) @(negedge clk);
        check_eq("reset_tx", tx_o, 0);
        check_eq("reset_lock", lock, 0);
        check_eq("reset_tick", gate_tick, 0);
        check_eq("reset_rd_err", rd_err_cnt, 0);
        check_eq("reset_rd_edge", rd_edge_cnt, 0);
        rst = 0;
        @(negedge clk);

        // PRBS7 loopback: lock after 2+7+16+1 = 26 cycles (+-1)
        mode = 2'd1; en = 1;
        wait_lock(5'h1F, 30, cyc);
        check_eq("prbs7_lock", lock, 5'h1F);
        $display("     prbs7 lock after %0d cycles", cyc);
        check_eq("prbs7_lock_time_26pm1", (cyc >= 25 && cyc <= 27), 1);
        repeat (10000) @(negedge clk);
        for (int c = 0; c < N_CH; c++) begin
            read_ch(c, e, g);
            check_eq($sformatf("prbs7_err_ch%0d", c), e, 0);
        end

        // Single-bit fault on channel 2: three bad compares, relock 16 good bits after the last
        mask = 5'b00100;
        @(negedge clk);
        mask = '0;
        cyc = 1; dropped = 0; relock = 0;
        while (cyc < 60 && relock == 0) begin
            @(negedge clk);
            cyc++;
            if (!lock[2]) dropped = 1;
            else if (dropped) relock = cyc;
        end
        check_eq("fault_lock2_dropped", dropped, 1);
        $display("     ch2 relock at cycle %0d", relock);
        check_eq("fault_relock_26pm1", (relock >= 25 && relock <= 27), 1);
        for (int c = 0; c < N_CH; c++) begin
            read_ch(c, e, g);
            check_eq($sformatf("fault_err_ch%0d", c), e, (c == 2) ? 3 : 0);
        end

        // Asynchronous reset mid-run
        read_ch(2, e, g);
        check_eq("pre_rst_err_ch2", e, 3);
        check_eq("pre_rst_lock", lock, 5'h1F);
        #2 rst = 1;
        #1;
        check_eq("async_rst_lock", lock, 0);
        check_eq("async_rst_tx", tx_o, 0);
        check_eq("async_rst_rd_err", rd_err_cnt, 0);
        check_eq("async_rst_rd_edge", rd_edge_cnt, 0);
        check_eq("async_rst_tick", gate_tick, 0);
        @(negedge clk);
        rst = 0;
        wait_lock(5'h1F, 35, cyc);
        $display("     relock after reset in %0d cycles", cyc);
        check_eq("rst_relock_time_26pm1", (cyc >= 25 && cyc <= 27), 1);

        // Toggle mode: 500 rising edges per 1000-cycle window
        mode = 2'd0;
        wait_tick(1100, cyc);
        check_eq("toggle_first_tick", gate_tick, 1);
        wait_tick(1100, cyc);
        check_eq("gate_period", cyc, GATE);
        @(negedge clk);
        check_eq("toggle_lock", lock, 5'h1F);
        for (int c = 0; c < 8; c++) begin
            read_ch(c, e, g);
            check_eq($sformatf("toggle_edge_sel%0d", c), g, (c < N_CH) ? 500 : 0);
            if (c >= N_CH) check_eq($sformatf("toggle_err_sel%0d", c), e, 0);
        end
        // Toggle fault on channel 1: two bad compares
        mask = 5'b00010;
        @(negedge clk);
        mask = '0;
        repeat (10) @(negedge clk);
        read_ch(1, e, g);
        check_eq("toggle_fault_err_ch1", e, 2);

        // Idle mode, RX held low
        hold0 = 1; mode = 2'd3;
        wait_tick(1100, cyc);
        wait_tick(1100, cyc);
        check_eq("idle_tick_seen", gate_tick, 1);
        @(negedge clk);
        check_eq("idle_tx", tx_o, 0);
        check_eq("idle_lock", lock, 0);
        read_ch(0, e, g);
        check_eq("idle_edge_ch0", g, 0);
        read_ch(1, e, g);
        check_eq("idle_err_ch1_kept", e, 2);

        // Saturation with 4-bit counters, PRBS15, then CLR
        mode_s = 2'd2; en_s = 1;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (lock_s !== 2'b11 && cyc <= 45);
        check_eq("sat_lock", lock_s, 2'b11);
        $display("     prbs15 lock after %0d cycles", cyc);
        check_eq("sat_lock_time_34pm1", (cyc >= 33 && cyc <= 35), 1);
        mask_s = 2'b01;
        repeat (100) @(negedge clk);
        rd_sel_s = 0;
        @(negedge clk);
        check_eq("sat_err_ch0", err_s, 15);
        check_eq("sat_lock_after_fault", lock_s, 2'b10);
        rd_sel_s = 1;
        @(negedge clk);
        check_eq("sat_err_ch1", err_s, 0);
        rd_sel_s = 0;
        @(negedge clk);
        clr_s = 1;
        @(negedge clk);
        clr_s = 0;
        @(negedge clk);
        check_eq("clr_err_ch0", err_s, 0);
        check_eq("clr_edge_ch0", edge_s, 0);
        check_eq("clr_tick", tick_s, 0);
        check_eq("clr_lock", lock_s, 2'b00);
        repeat (20) @(negedge clk);
        check_eq("clr_err_ch0_stays", err_s, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/io_loopback_tester.md
# io_loopback_tester

Parametrised N-channel IO loopback tester for board bring-up of single-ended and LVDS-pair test lines. It is the multi-channel successor to the per-line GPIO and LVDS activity counters in the IO test subsystem. Per channel it drives a selectable pattern (toggle, PRBS7, PRBS15 or idle), synchronises the returned line and checks it with a self-synchronising checker. It keeps per-channel lock, saturating error counts and gated rising-edge counts, read through a registered channel-select port by the IO register block.

## Interface
- N_CH, 5, number of channels
- CNT_W, 32, width of error and edge counters
- GATE_CYCLES, 50000000, edge-count gate window in CLK cycles (1 s at 50 MHz)
- SYNC_STAGES, 2, RX synchroniser depth (>=2)
- LOCK_THRESH, 16, consecutive good bits needed to assert lock
- CLK  in  1  block clock
- RST  in  1  reset, asynchronous, active-high
- EN  in  1  1 = generate and check patterns
- MODE  in  2  0 toggle, 1 PRBS7, 2 PRBS15, 3 idle
- CLR  in  1  1-cycle pulse: clear counters, lock, gate timer
- TX_O  out  N_CH  pattern outputs, registered
- RX_I  in  N_CH  returned lines, asynchronous
- LOCK  out  N_CH  per-channel lock status
- GATE_TICK  out  1  1-cycle pulse at end of each gate window
- RD_SEL  in  max(1,clog2(N_CH))  channel select for readback
- RD_ERR_CNT  out  CNT_W  error count of selected channel, registered
- RD_EDGE_CNT  out  CNT_W  latched edge count of selected channel, registered

## Operation
- All channels share one generator. Every TX_O bit carries the same pattern.
- Toggle: TX starts at 0 and inverts every cycle.
- PRBS7: polynomial x^7+x^6+1, seed 7'h7F, output = LFSR MSB.
- PRBS15: polynomial x^15+x^14+1, seed all ones.
- Idle (MODE=3): TX_O=0, checker disabled.
- EN=0: TX_O=0, generator held at seed, checkers held, history fill and LOCK/ARMED cleared. Error counts are held.
- An EN rise or a MODE change while EN=1 restarts the generator at its seed and clears history fill, run counter, LOCK and ARMED. Error counts are kept.
- RX path: SYNC_STAGES-flop synchroniser per channel, then a history shift register h (h[0] newest).
- Checker runs only after the history is filled since the last restart: 1 bit (toggle), 7 bits (PRBS7), 15 bits (PRBS15).
- Expected bit: toggle ~h[0]; PRBS7 h[6]^h[5]; PRBS15 h[14]^h[13].
- Good bit: run counter +1, saturating at LOCK_THRESH. LOCK=1 when run counter = LOCK_THRESH. First lock sets ARMED.
- Bad bit: run counter=0, LOCK=0. Error counter +1 only if ARMED. The counter saturates at 2^CNT_W-1.
- Edge counting is independent of EN and MODE: a rising edge on the synchronised RX increments the running counter, which saturates.
- Gate timer counts 0..GATE_CYCLES-1. In the cycle it equals GATE_CYCLES-1, GATE_TICK=1, running counters (including any edge in that cycle) are copied to the latched counters, and the running counters reset to 0.
- CLR clears error, running and latched edge counters, run counters, LOCK, ARMED and the gate timer. History fill is kept. CLR wins over any simultaneous increment or latch.
- Readback: RD_ERR_CNT and RD_EDGE_CNT are registered from RD_SEL. RD_SEL >= N_CH returns 0.

## Timing
- Reset values: TX_O=0, LOCK=0, GATE_TICK=0, RD_ERR_CNT=0, RD_EDGE_CNT=0. Generator at seed; all counters, ARMED and history cleared.
- TX_O changes the first cycle after EN is sampled 1.
- RX-to-checker latency: SYNC_STAGES cycles, plus 1 for the history register.
- Earliest LOCK after restart in perfect loopback with TX_O wired directly to RX_I: SYNC_STAGES+fill+LOCK_THRESH+1 cycles. Bench tolerance is ±1.
- Readback latency: 1 cycle from RD_SEL or counter update.
- GATE_TICK period: exactly GATE_CYCLES cycles after reset or CLR.
- RST asserted mid-run returns every output to its reset value immediately, without waiting for CLK.

## Test plan
- PRBS7 loopback: N_CH=5, GATE_CYCLES=1000, TX_O->RX_I, EN=1. LOCK=5'h1F within 30 cycles. After 10000 cycles every RD_ERR_CNT is 0.
- Single-bit fault: after lock, invert RX_I[2] for one cycle. Channel 2 RD_ERR_CNT=3, LOCK[2] drops, LOCK[2] re-asserts 16 good bits later. All other channels stay at 0.
- Toggle mode, loopback, GATE_CYCLES=1000: every window latches RD_EDGE_CNT=500 on all channels. GATE_TICK period is 1000.
- MODE=3 with RX_I held at 0: TX_O=0, RD_EDGE_CNT=0, RD_ERR_CNT unchanged, LOCK=0.
- Saturation and clear: CNT_W=4, PRBS15, RX_I[0] forced to inverted TX after lock. RD_ERR_CNT[0] stops at 15. A CLR pulse gives 0 one cycle later.
- Async reset: assert RST mid-PRBS with counters nonzero. Outputs go to 0 before the next CLK edge. After release, re-lock follows the earliest-LOCK timing above.
